// File: rtl/controle_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving an
// external register bank, instruction memory and data memory.
module controle_multiciclo #(
  parameter logic [7:0] PC_INICIAL = 8'h00
) (
  input  logic        clk,
  input  logic        clr,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr,
  output logic [3:0]  rf_rd1,
  output logic [3:0]  rf_rd2,
  input  logic [7:0]  rf_q1,
  input  logic [7:0]  rf_q2,
  output logic [3:0]  rf_wsel,
  output logic [7:0]  rf_wdata,
  output logic        rf_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [7:0]  mem_q,
  output logic        halted,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_LI   = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BZ   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  res_q, res_d;

  logic [3:0] op, rd, rs, rt;
  logic [7:0] imm;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign rs  = ir_q[7:4];
  assign rt  = ir_q[3:0];
  assign imm = ir_q[7:0];

  // State, PC, IR and result registers; reset clears everything at once
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INICIAL;
      ir_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic; JMP/BZ targets replace the increment done in FETCH
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD:  begin res_d = rf_q1 + rf_q2; state_d = S_WB; end
          OP_SUB:  begin res_d = rf_q1 - rf_q2; state_d = S_WB; end
          OP_AND:  begin res_d = rf_q1 & rf_q2; state_d = S_WB; end
          OP_OR:   begin res_d = rf_q1 | rf_q2; state_d = S_WB; end
          OP_LI:   begin res_d = imm;           state_d = S_WB; end
          OP_LD,
          OP_ST:   state_d = S_MEM;
          OP_JMP:  begin pc_d = imm; state_d = S_FETCH; end
          OP_BZ:   begin
            if (rf_q1 == 8'h00) pc_d = imm;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (op == OP_LD) begin
          res_d   = mem_q;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs decoded from state and IR; strobes and write buses are gated to
  // their own state so they read zero everywhere else (including reset)
  always_comb begin
    instr_addr = pc_q;
    rf_rd1     = (op == OP_BZ) ? rd : rs;
    rf_rd2     = rt;
    rf_we      = (state_q == S_WB);
    rf_wsel    = (state_q == S_WB) ? rd : 4'h0;
    rf_wdata   = (state_q == S_WB) ? res_q : 8'h00;
    mem_read   = (state_q == S_MEM) && (op == OP_LD);
    mem_write  = (state_q == S_MEM) && (op == OP_ST);
    mem_addr   = (state_q == S_MEM) ? rf_q1 : 8'h00;
    mem_wdata  = ((state_q == S_MEM) && (op == OP_ST)) ? rf_q2 : 8'h00;
    halted     = (state_q == S_HALT);
    estado     = state_q;
  end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter: PC_INICIAL, default 8'h00, PC value loaded on reset.
REQ-002 Timing: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  system clock; all state changes on posedge.
REQ-004 Port: clr  in  1  asynchronous active-low reset.
REQ-005 Port: instr_addr  out  8  instruction memory address, equal to PC.
REQ-006 Port: instr  in  16  instruction word at instr_addr, valid combinationally.
REQ-007 Port: rf_rd1, rf_rd2  out  4 each  register bank read selects (entrada1/entrada2).
REQ-008 Port: rf_q1, rf_q2  in  8 each  register bank read data (saida1/saida2).
REQ-009 Port: rf_wsel  out  4  write register select; rf_wdata  out  8  write data; rf_we  out  1  write enable.
REQ-010 Port: mem_addr  out  8; mem_wdata  out  8; mem_read  out  1; mem_write  out  1; mem_q  in  8  data memory interface.
REQ-011 Port: halted  out  1  high once HALT executes; estado  out  3  current FSM state, for debug.

Function
REQ-012 Instruction fields: op=instr[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm=[7:0].
REQ-013 Opcodes: 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 AND; 4 OR; 5 LI rd=imm; 6 LD rd=mem[R[rs]]; 7 ST mem[R[rs]]=R[rt]; 8 JMP PC=imm; 9 BZ if R[rd]==0 then PC=imm; 15 HALT; 10-14 execute as NOP.
REQ-014 Arithmetic is 8-bit modulo 256; no carry, no flags.
REQ-015 FSM states (estado encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-016 FETCH: at posedge, IR<=instr, PC<=PC+1 (255 wraps to 0); next state DECODE.
REQ-017 DECODE: rf_rd1=rs (rd for BZ), rf_rd2=rt, held constant through EXEC and MEM; next EXEC.
REQ-018 EXEC: register ALU/LI result from rf_q1/rf_q2 sampled at this posedge.
REQ-019 EXEC transitions: ADD/SUB/AND/OR/LI -> WB; LD/ST -> MEM; JMP -> FETCH with PC<=imm; BZ -> FETCH with PC<=imm only if rf_q1==0; NOP/undefined -> FETCH; HALT -> HALT.
REQ-020 MEM: mem_addr=R[rs]; LD drives mem_read=1, captures mem_q at end of MEM, next WB; ST drives mem_write=1 and mem_wdata=R[rt], next FETCH.
REQ-021 WB: rf_we=1 for exactly this one cycle, rf_wsel=rd, rf_wdata=result; next FETCH.
REQ-022 rf_we, mem_read and mem_write SHALL never be high outside WB/MEM, and never simultaneously.
REQ-023 Cycle counts: NOP/JMP/BZ 3; ALU/LI 4; ST 4; LD 5.
REQ-024 HALT: state absorbing; halted=1; PC frozen; all enables 0 until reset.
REQ-025 JMP/BZ target overrides the FETCH increment; a branch to 255 followed by fetch wraps PC to 0.

Reset
REQ-026 clr low forces immediately (no clock needed): state FETCH, PC=PC_INICIAL, IR=0, result=0, rf_we=mem_read=mem_write=0, halted=0, all address/data outputs 0.
REQ-027 Reset asserted mid-instruction aborts it; no write or memory strobe SHALL follow in the cycle after clr returns high.
REQ-028 First FETCH occurs at the first posedge after clr deasserts.

Verification
REQ-029 Reset: clr=0 during MEM of ST -> mem_write falls at once, estado=0, instr_addr=00.
REQ-030 LI R1,5; LI R2,3; ADD R3,R1,R2 -> WB of 3rd instr: rf_we=1, rf_wsel=3, rf_wdata=08; ADD completes at cycle 12.
REQ-031 SUB with R1=02, R2=05 -> rf_wdata=FD (wrap).
REQ-032 ST mem[R1]=R2 with R1=10, R2=AA, then LD R4,[R1] -> mem_write one cycle at addr 10 data AA; later rf_wdata=AA, rf_wsel=4.
REQ-033 BZ R0,imm=40 with R0=00 -> next instr_addr=40; with R0=01 -> PC+1; JMP FF then NOP -> instr_addr 00 after it.
REQ-034 HALT -> halted=1, estado=5, instr_addr stable, no strobes for 20 cycles; clr pulse restarts at 00.
